// File: rtl/ysyx_22050854_mul_ctrl.sv
// Multiply controller between EX and the shift-add multiplier: decodes RV64M multiply ops,
// runs the multiplier handshake, stalls EX, and returns a formatted result to writeback.
module ysyx_22050854_mul_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [1:0]  ex_mul_op,
  input  logic        ex_is_word,
  input  logic [63:0] ex_src1,
  input  logic [63:0] ex_src2,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        ex_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        mul_err,
  output logic        mul_valid,
  output logic        mulw,
  output logic [1:0]  mul_signed,
  output logic [63:0] multiplicand,
  output logic [63:0] multiplier,
  input  logic        mul_ready,
  input  logic        out_valid,
  input  logic [63:0] result_hi,
  input  logic [63:0] result_lo
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q;
  logic            is_word_q;
  logic [4:0]      rd_q;
  logic            capture;
  logic            timeout;
  logic [63:0]     sel_result;

  assign capture = (state_q == StIdle) && ex_valid && !flush;
  assign timeout = ((state_q == StWait) || (state_q == StDrain)) &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    if (is_word_q) begin
      sel_result = {{32{result_lo[31]}}, result_lo[31:0]};
    end else if (op_q == 2'b00) begin
      sel_result = result_lo;
    end else begin
      sel_result = result_hi;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_valid = 1'b0;
    wb_valid  = 1'b0;
    ex_stall  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ex_stall = ex_valid;
        if (capture) state_d = StIssue;
      end
      StIssue: begin
        ex_stall  = 1'b1;
        mul_valid = !flush;
        if (flush) begin
          state_d = StIdle;
        end else if (mul_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        ex_stall = 1'b1;
        cnt_d    = cnt_q + CntW'(1);
        if (flush) begin
          // A result arriving with the flush is simply dropped; otherwise wait it out.
          state_d = out_valid ? StIdle : StDrain;
          cnt_d   = '0;
        end else if (out_valid || timeout) begin
          state_d = StDone;
        end
      end
      StDone: begin
        wb_valid = !flush;
        state_d  = StIdle;
      end
      StDrain: begin
        ex_stall = ex_valid;
        cnt_d    = cnt_q + CntW'(1);
        if (out_valid || timeout) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= '0;
      is_word_q    <= 1'b0;
      rd_q         <= '0;
      mulw         <= 1'b0;
      mul_signed   <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      wb_rd        <= '0;
      wb_data      <= '0;
      mul_err      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_err <= (state_q == StWait) && !flush && !out_valid && timeout;
      if (capture) begin
        op_q      <= ex_mul_op;
        is_word_q <= ex_is_word;
        rd_q      <= ex_rd;
        if (ex_is_word) begin
          // Zero-extended multiplier lets the shift-add unit stop after 32 bits.
          mulw         <= 1'b1;
          mul_signed   <= 2'b11;
          multiplicand <= {{32{ex_src1[31]}}, ex_src1[31:0]};
          multiplier   <= {32'b0, ex_src2[31:0]};
        end else begin
          mulw         <= 1'b0;
          multiplicand <= ex_src1;
          multiplier   <= ex_src2;
          unique case (ex_mul_op)
            2'b10:   mul_signed <= 2'b10;
            2'b11:   mul_signed <= 2'b00;
            default: mul_signed <= 2'b11;
          endcase
        end
      end
      if ((state_q == StWait) && !flush) begin
        if (out_valid) begin
          wb_data <= sel_result;
          wb_rd   <= rd_q;
        end else if (timeout) begin
          wb_data <= '0;
          wb_rd   <= rd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_mul_ctrl.sv
// Randomised bench for the multiply controller: stub multiplier, op-level reference model,
// scoreboarded writebacks and a per-cycle compare process.
module tb_ysyx_22050854_mul_ctrl;

  localparam int unsigned T = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [1:0]  ex_mul_op;
  logic        ex_is_word;
  logic [63:0] ex_src1, ex_src2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        ex_stall, wb_valid, mul_err, mul_valid, mulw;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, multiplicand, multiplier;
  logic [1:0]  mul_signed;
  logic        mul_ready, out_valid;
  logic [63:0] result_hi, result_lo;

  always #5 clock = ~clock;

  ysyx_22050854_mul_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_mul_op(ex_mul_op),
    .ex_is_word(ex_is_word), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_rd(ex_rd),
    .flush(flush), .ex_stall(ex_stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .mul_err(mul_err), .mul_valid(mul_valid), .mulw(mulw),
    .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_ready(mul_ready), .out_valid(out_valid), .result_hi(result_hi),
    .result_lo(result_lo)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: what RV64M says each op returns.
  function automatic logic [63:0] exp_result(logic [1:0] op, logic w, logic [63:0] a,
                                             logic [63:0] b);
    logic [127:0] ea, eb, p;
    if (w) begin
      p = {64'b0, a} * {64'b0, b};
      return {{32{p[31]}}, p[31:0]};
    end
    ea = (op == 2'b11) ? {64'b0, a} : {{64{a[63]}}, a};
    eb = (op == 2'b00 || op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Stub multiplier: fixed per-op latency, result bus carries junk outside the pulse.
  function automatic logic [127:0] stub_mul(logic [63:0] a, logic [63:0] b, logic [1:0] s);
    logic [127:0] ea, eb;
    ea = s[1] ? {{64{a[63]}}, a} : {64'b0, a};
    eb = s[0] ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  logic         busy;
  int           scnt;
  int           stub_lat;
  bit           stub_hang;
  int           hs_cyc, hs_lat;
  logic [127:0] prod_q;

  assign mul_ready = !busy;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      scnt      <= 0;
      out_valid <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      out_valid <= 1'b0;
      result_hi <= {$urandom, $urandom};
      result_lo <= {$urandom, $urandom};
      if (busy) begin
        if (scnt == 2) begin
          out_valid              <= 1'b1;
          {result_hi, result_lo} <= prod_q;
          busy                   <= 1'b0;
        end else begin
          scnt <= scnt - 1;
        end
      end else if (mul_valid && mul_ready) begin
        hs_cyc <= cyc;
        hs_lat <= stub_lat;
        if (!stub_hang) begin
          if (stub_lat == 1) begin
            out_valid              <= 1'b1;
            {result_hi, result_lo} <= stub_mul(multiplicand, multiplier, mul_signed);
          end else begin
            busy   <= 1'b1;
            scnt   <= stub_lat;
            prod_q <= stub_mul(multiplicand, multiplier, mul_signed);
          end
        end
      end
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  logic [1:0]  cur_op;
  logic        cur_w;
  logic [63:0] cur_a, cur_b;
  int          present_cyc;
  bit          chk_accept;
  int          op_id = 0;
  int          issued_id = 0;

  // Compare process: operand formatting on issue, writebacks against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (mul_valid) begin
        chk("mul_valid_while_busy", 64'(busy), 64'd0);
        if (issued_id != op_id) begin
          issued_id <= op_id;
          chk("mulw", 64'(mulw), 64'(cur_w));
          chk("mul_signed", 64'(mul_signed),
              cur_w ? 64'd3 : (cur_op == 2'b10) ? 64'd2 : (cur_op == 2'b11) ? 64'd0 : 64'd3);
          chk("multiplicand", multiplicand,
              cur_w ? {{32{cur_a[31]}}, cur_a[31:0]} : cur_a);
          chk("multiplier", multiplier, cur_w ? {32'b0, cur_b[31:0]} : cur_b);
          if (chk_accept) chk("issue_cycle", 64'(cyc), 64'(present_cyc + 1));
        end
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb_valid", 64'(wb_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_rd", 64'(wb_rd), 64'(e.rd));
          chk("mul_err", 64'(mul_err), 64'(e.err));
          chk("wb_latency", 64'(cyc),
              e.err ? 64'(hs_cyc + int'(T) + 1) : 64'(hs_cyc + hs_lat + 1));
        end
      end else if (mul_err) begin
        chk("stray_mul_err", 64'(mul_err), 64'd0);
      end
    end
  end

  task automatic present_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] rd, input int lat,
                            input bit hang, input bit expect_wb, input bit acc);
    exp_t e;
    cur_op      = op;
    cur_w       = w;
    cur_a       = a;
    cur_b       = b;
    stub_lat    = lat;
    stub_hang   = hang;
    chk_accept  = acc;
    present_cyc = cyc;
    op_id++;
    if (expect_wb) begin
      e.rd   = rd;
      e.data = hang ? 64'd0 : exp_result(op, w, a, b);
      e.err  = hang;
      exp_q.push_back(e);
    end
    ex_valid   = 1'b1;
    ex_mul_op  = op;
    ex_is_word = w;
    ex_src1    = a;
    ex_src2    = b;
    ex_rd      = rd;
  endtask

  task automatic finish_op();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clock);
      if (!ex_stall) break;
    end
    if (k == 200) chk("retire_bound", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    ex_valid = 1'b0;
    ex_src1  = {$urandom, $urandom};
    ex_src2  = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int lat,
                        input bit hang);
    present_op(op, w, a, b, rd, lat, hang, 1'b1, 1'b1);
    finish_op();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_stall"}, 64'(ex_stall), 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    chk({tag, "_wb_data"}, wb_data, 64'd0);
    chk({tag, "_mul_err"}, 64'(mul_err), 64'd0);
    chk({tag, "_mul_valid"}, 64'(mul_valid), 64'd0);
    chk({tag, "_mulw"}, 64'(mulw), 64'd0);
    chk({tag, "_mul_signed"}, 64'(mul_signed), 64'd0);
    chk({tag, "_multiplicand"}, multiplicand, 64'd0);
    chk({tag, "_multiplier"}, multiplier, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [63:0] specials [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                64'h0000_0000_8000_0000, 64'h0};

  initial begin
    reset      = 1'b1;
    ex_valid   = 1'b0;
    ex_mul_op  = '0;
    ex_is_word = 1'b0;
    ex_src1    = '0;
    ex_src2    = '0;
    ex_rd      = '0;
    flush      = 1'b0;
    stub_lat   = 1;
    stub_hang  = 1'b0;
    #1;
    chk_all_zero("reset");
    #12;
    @(negedge clock);
    reset = 1'b0;

    // Hand-computed anchors for the reference model.
    chk("model_mulw", exp_result(2'b00, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd3),
        64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_mul", exp_result(2'b00, 1'b0, Ones, Ones), 64'd1);
    chk("model_mulh", exp_result(2'b01, 1'b0, Ones, Ones), 64'd0);
    chk("model_mulhu", exp_result(2'b11, 1'b0, Ones, Ones), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("model_mulhsu", exp_result(2'b10, 1'b0, Ones, 64'd2), Ones);
    chk("model_mul_5x7", exp_result(2'b00, 1'b0, 64'd5, 64'd7), 64'd35);

    @(posedge clock);
    #1;
    run_op(2'b00, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd3, 5'd5, 3, 1'b0);
    run_op(2'b00, 1'b0, Ones, Ones, 5'd6, 2, 1'b0);
    run_op(2'b01, 1'b0, Ones, Ones, 5'd7, 4, 1'b0);
    run_op(2'b11, 1'b0, Ones, Ones, 5'd8, 1, 1'b0);
    run_op(2'b10, 1'b0, Ones, 64'd2, 5'd10, 2, 1'b0);
    run_op(2'b11, 1'b0, 64'd2, 64'd3, 5'd11, 3, 1'b0);

    // Watchdog: multiplier accepts but never answers.
    run_op(2'b00, 1'b0, 64'd7, 64'd7, 5'd12, 1, 1'b1);

    // Flush in WAIT, then a new op that must wait for the drain.
    present_op(2'b00, 1'b0, 64'd9, 64'd9, 5'd3, 6, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    flush    = 1'b1;
    ex_valid = 1'b0;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    chk("drain_stall_idle", 64'(ex_stall), 64'd0);
    @(posedge clock);
    #1;
    present_op(2'b00, 1'b0, 64'd5, 64'd7, 5'd9, 2, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    chk("drain_stall_busy", 64'(ex_stall), 64'd1);
    finish_op();

    // Asynchronous reset while waiting on the multiplier.
    present_op(2'b00, 1'b0, 64'd6, 64'd6, 5'd4, 5, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    ex_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_op(2'b00, 1'b0, 64'd4, 64'd4, 5'd13, 3, 1'b0);

    for (int i = 0; i < 25; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = specials[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = specials[$urandom_range(0, 3)];
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), a, b,
             5'($urandom_range(0, 31)), $urandom_range(1, 6), 1'b0);
    end

    repeat (10) @(negedge clock);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_mul_ctrl.md
# ysyx_22050854_mul_ctrl

- Sits in EXU between the issue/decode side and the shift-add multiplier.
- Decodes RV64M multiply ops (mul, mulh, mulhsu, mulhu, mulw) and formats operands and sign control for the multiplier.
- Runs the multiplier's valid/ready handshake and stalls EX until the result returns.
- Latches the multiplier's one-cycle `out_valid`/result pulse, selects and sign-extends the result, and hands it to writeback. Supports pipeline flush and a watchdog timeout.

## Interface
- `TIMEOUT_CYCLES`, default 128: max cycles in WAIT/DRAIN without `out_valid` before abort.
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `ex_valid`  in  1  multiply instruction present in EX.
- `ex_mul_op`  in  2  00 mul, 01 mulh, 10 mulhsu, 11 mulhu.
- `ex_is_word`  in  1  1 = mulw; `ex_mul_op` ignored.
- `ex_src1`, `ex_src2`  in  64  rs1, rs2 values.
- `ex_rd`  in  5  destination register.
- `flush`  in  1  kill the in-flight multiply.
- `ex_stall`  out  1  hold EX/upstream.
- `wb_valid`  out  1  one-cycle result strobe.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  64  result.
- `mul_err`  out  1  one-cycle timeout pulse.
- `mul_valid`  out  1  multiplier request.
- `mulw`  out  1  32-bit mode.
- `mul_signed`  out  2  11 s×s, 10 s×u, 00 u×u.
- `multiplicand`, `multiplier`  out  64  operands.
- `mul_ready`  in  1  multiplier idle and accepting.
- `out_valid`  in  1  one-cycle result-valid pulse.
- `result_hi`, `result_lo`  in  64  product; valid only while `out_valid`=1.

## Operation
- **Operand capture.** IDLE with `ex_valid` & ~`flush` captures into internal registers: src1, src2, rd, op, is_word.
- **Multiplier drive.** Operand/control outputs come from the captured registers only.
  - Word op: `mulw`=1, `mul_signed`=11 (required; the 32-bit path runs only for signed×signed). `multiplicand`={{32{src1[31]}},src1[31:0]}, `multiplier`={32'b0,src2[31:0]} so the multiplier can terminate early.
  - mul and mulh: `mul_signed`=11. mulhsu: 10. mulhu: 00. Operands passed unchanged with `mulw`=0.
- **Result select.** mulw: {{32{result_lo[31]}},result_lo[31:0]}. mul: result_lo. mulh/mulhsu/mulhu: result_hi. Latched only on `out_valid`.
- **States.**
  - IDLE: capture on `ex_valid` & ~`flush` → ISSUE.
  - ISSUE: `mul_valid` = ~`flush`. `flush` → IDLE. Else `mul_ready`=1 → WAIT (handshake taken at this edge). Else hold.
  - WAIT: `out_valid` → latch result, DONE. `flush` (without `out_valid`) → DRAIN. Timeout → DONE with `wb_data`=0 and `mul_err` pulse.
  - DONE: `wb_valid` = ~`flush` for exactly one cycle, then → IDLE.
  - DRAIN: discard the result; `out_valid` or timeout → IDLE.
- **Watchdog counter.** Cleared on entering WAIT or DRAIN; increments each cycle in those states. Timeout fires when count = `TIMEOUT_CYCLES`-1.
- **Stall.** `ex_stall` = (`ex_valid` & state∈{IDLE,DRAIN}) | state∈{ISSUE,WAIT}. It is low in DONE, so upstream advances in the same cycle `wb_valid` is high.
- **Simultaneous events.**
  - `out_valid` and `flush` in WAIT: flush wins, → IDLE, nothing written back.
  - `flush` and `ex_valid` in IDLE: no capture.

## Timing
- **Reset (async):** state IDLE; all outputs 0; counter 0; captured registers 0.
- **Reset mid-operation:** controller returns to IDLE immediately. The multiplier is reset by the same `reset`.
- **Latency, accept to `wb_valid`:** 2 + N cycles, where N = cycles from the handshake edge to `out_valid`.
  - Edge 0: accept.
  - Cycle 1: ISSUE handshake.
  - `out_valid` in cycle 1+N.
  - DONE (`wb_valid`) in cycle 2+N.
- **Back-to-back:** the next instruction is accepted no earlier than the cycle after DONE (one idle cycle minimum). No overlap.
- **Outputs:** `wb_data`/`wb_rd` are registered and stable during DONE. `mul_valid` is never asserted outside ISSUE.

## Test plan
- mulw src1=0x00000000FFFFFFFF, src2=3 → `mulw`=1, `mul_signed`=11, `multiplier`=0x3. `wb_data`=0xFFFFFFFFFFFFFFFD, single `wb_valid`, `wb_rd` echoed.
- mul / mulh / mulhu with src1=src2=0xFFFFFFFFFFFFFFFF:
  - mul → 0x0000000000000001.
  - mulh → 0x0000000000000000.
  - mulhu → 0xFFFFFFFFFFFFFFFE.
  - `mul_signed` 11 / 11 / 00 respectively.
- mulhsu src1=0xFFFFFFFFFFFFFFFF, src2=2 → `mul_signed`=10, `wb_data`=0xFFFFFFFFFFFFFFFF. Back-to-back second op (mulhu 2×3 → 0) is accepted the cycle after DONE.
- Flush while in WAIT → no `wb_valid`. `ex_stall` drops; the controller sits in DRAIN until `out_valid`. A new mul 5×7 stalls until DRAIN exits, then returns 35.
- Stub multiplier with `out_valid` held 0 and `TIMEOUT_CYCLES`=8 → after 8 WAIT cycles: `mul_err` pulse, `wb_valid` with `wb_data`=0, return to IDLE.
- Assert `reset` during WAIT → all outputs 0 the same cycle, state IDLE. A subsequent mul 4×4 returns 16.
